bus_endpoint: RTL and testbench

//  Per-core attachment to the shared instruction bus; one instance per core.
//  TX side: buffers one outgoing instruction from the core, drives send_req/dst/broadcast, and retires on send_grant.
//  RX side: captures bus deliveries addressed to this core into a show-ahead FIFO.
//  RX side also decodes control instructions into a core run-state FSM and a per-source DONE mask.

---
 rtl/bus_endpoint.sv | 167 ++++++++++++++++
 tb/tb_bus_endpoint.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_endpoint.sv
// bus_endpoint: per-core attachment to the shared instruction bus.
// Single-entry TX holding register, show-ahead RX FIFO, control decode.
module bus_endpoint #(
    parameter int NUM_CORES   = 4,
    parameter int INSTR_WIDTH = 2,
    parameter int CORE_ID     = 0,
    parameter int FIFO_DEPTH  = 4,
    localparam int CORE_ID_WIDTH = $clog2(NUM_CORES)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    input  logic                     tx_broadcast,
    input  logic [CORE_ID_WIDTH-1:0] tx_dst_id,
    input  logic [INSTR_WIDTH-1:0]   tx_instr,
    output logic                     send_req,
    output logic                     broadcast_mode,
    output logic [CORE_ID_WIDTH-1:0] dst_id,
    output logic [INSTR_WIDTH-1:0]   instr_out,
    input  logic                     send_grant,
    input  logic                     recv_valid,
    input  logic [CORE_ID_WIDTH-1:0] src_id,
    input  logic [INSTR_WIDTH-1:0]   instruction,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic [CORE_ID_WIDTH-1:0] rx_src_id,
    output logic [INSTR_WIDTH-1:0]   rx_instr,
    output logic                     rx_overflow,
    output logic [1:0]               core_state,
    output logic [NUM_CORES-1:0]     done_mask,
    input  logic                     done_clear
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = CORE_ID_WIDTH + INSTR_WIDTH;

    localparam logic [INSTR_WIDTH-1:0] I_HALT = INSTR_WIDTH'(0);
    localparam logic [INSTR_WIDTH-1:0] I_STOP = INSTR_WIDTH'(1);
    localparam logic [INSTR_WIDTH-1:0] I_CONT = INSTR_WIDTH'(2);
    localparam logic [INSTR_WIDTH-1:0] I_DONE = INSTR_WIDTH'(3);

    if (CORE_ID < 0 || CORE_ID >= NUM_CORES) begin : g_bad_core_id
        $error("bus_endpoint: CORE_ID out of range");
    end

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_PAUSED  = 2'b01,
        ST_STOPPED = 2'b10
    } state_t;

    // ---------------- TX ----------------
    logic tx_pending;
    logic tx_load;

    assign tx_ready = !tx_pending | send_grant;
    assign tx_load  = tx_valid & tx_ready;
    // Grant mask keeps the arbiter from granting the same entry twice.
    assign send_req = tx_pending & !send_grant;

    // Hold the outgoing instruction until the bus grants it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_pending     <= 1'b0;
            broadcast_mode <= 1'b0;
            dst_id         <= '0;
            instr_out      <= '0;
        end else if (tx_load) begin
            tx_pending     <= 1'b1;
            broadcast_mode <= tx_broadcast;
            dst_id         <= tx_dst_id;
            instr_out      <= tx_instr;
        end else if (send_grant) begin
            tx_pending     <= 1'b0;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop  = !fifo_empty & rx_ready;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign push = recv_valid & (!fifo_full | pop);

    assign rx_valid = !fifo_empty;
    assign {rx_src_id, rx_instr} = mem[rd_ptr[PTR_W-1:0]];

    // FIFO storage, pointers and sticky overflow flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr[PTR_W-1:0]] <= {src_id, instruction};
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
            if (recv_valid && !push) begin
                rx_overflow <= 1'b1;
            end
        end
    end

    // ---------------- Control decode ----------------
    state_t         state_q;
    state_t         state_d;
    logic [NUM_CORES-1:0] done_d;

    // Run-state and DONE-mask registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_RUN;
            done_mask <= '0;
        end else begin
            state_q   <= state_d;
            done_mask <= done_d;
        end
    end

    // Next run-state from every delivery, accepted into the FIFO or not.
    always_comb begin
        state_d = state_q;
        if (recv_valid) begin
            case (state_q)
                ST_PAUSED: begin
                    if (instruction == I_CONT)      state_d = ST_RUN;
                    else if (instruction == I_STOP) state_d = ST_STOPPED;
                end
                ST_STOPPED: begin
                    if (instruction == I_CONT)      state_d = ST_RUN;
                end
                default: begin
                    if (instruction == I_HALT)      state_d = ST_PAUSED;
                    else if (instruction == I_STOP) state_d = ST_STOPPED;
                end
            endcase
        end
    end

    // DONE set takes priority over a coincident clear for its own bit.
    always_comb begin
        done_d = done_clear ? '0 : done_mask;
        if (recv_valid && instruction == I_DONE) begin
            done_d[src_id] = 1'b1;
        end
    end

    assign core_state = state_q;

endmodule

// File: tb/tb_bus_endpoint.sv
// tb_bus_endpoint: directed stimulus, queue-based reference model
// compared every cycle, plus literal expectations per scenario.
module tb_bus_endpoint;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_broadcast = 1'b0;
    logic [1:0] tx_dst_id = '0;
    logic [1:0] tx_instr = '0;
    logic       send_req;
    logic       broadcast_mode;
    logic [1:0] dst_id;
    logic [1:0] instr_out;
    logic       send_grant = 1'b0;
    logic       recv_valid = 1'b0;
    logic [1:0] src_id = '0;
    logic [1:0] instruction = '0;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [1:0] rx_src_id;
    logic [1:0] rx_instr;
    logic       rx_overflow;
    logic [1:0] core_state;
    logic [3:0] done_mask;
    logic       done_clear = 1'b0;

    bus_endpoint #(
        .NUM_CORES(4), .INSTR_WIDTH(2), .CORE_ID(0), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_broadcast(tx_broadcast), .tx_dst_id(tx_dst_id),
        .tx_instr(tx_instr), .send_req(send_req),
        .broadcast_mode(broadcast_mode), .dst_id(dst_id),
        .instr_out(instr_out), .send_grant(send_grant),
        .recv_valid(recv_valid), .src_id(src_id),
        .instruction(instruction), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .rx_src_id(rx_src_id),
        .rx_instr(rx_instr), .rx_overflow(rx_overflow),
        .core_state(core_state), .done_mask(done_mask),
        .done_clear(done_clear)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                      name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    bit         m_pend = 1'b0;
    logic       m_bc = 1'b0;
    logic [1:0] m_dst = '0;
    logic [1:0] m_ins = '0;
    logic [3:0] q[$];
    bit         m_ovf = 1'b0;
    int         m_state = 0;
    logic [3:0] m_done = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pend = 1'b0;
            q.delete();
            m_ovf = 1'b0;
            m_state = 0;
            m_done = '0;
        end else begin
            if (tx_valid && (!m_pend || send_grant)) begin
                m_pend = 1'b1;
                m_bc = tx_broadcast;
                m_dst = tx_dst_id;
                m_ins = tx_instr;
            end else if (send_grant) begin
                m_pend = 1'b0;
            end
            if (q.size() > 0 && rx_ready) void'(q.pop_front());
            if (recv_valid) begin
                if (q.size() < DEPTH) q.push_back({src_id, instruction});
                else m_ovf = 1'b1;
                case (instruction)
                    2'd0: if (m_state == 0) m_state = 1;
                    2'd1: m_state = 2;
                    2'd2: m_state = 0;
                    default: ;
                endcase
            end
            if (done_clear) m_done = '0;
            if (recv_valid && instruction == 2'd3) m_done[src_id] = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("m_tx_ready", tx_ready, (!m_pend || send_grant));
            chk("m_send_req", send_req, (m_pend && !send_grant));
            chk("m_rx_valid", rx_valid, (q.size() > 0));
            chk("m_overflow", rx_overflow, m_ovf);
            chk("m_state", core_state, m_state);
            chk("m_done", done_mask, m_done);
            if (m_pend) begin
                chk("m_dst", dst_id, m_dst);
                chk("m_bc", broadcast_mode, m_bc);
                chk("m_instr_out", instr_out, m_ins);
            end
            if (q.size() > 0) begin
                chk("m_rx_src", rx_src_id, q[0][3:2]);
                chk("m_rx_instr", rx_instr, q[0][1:0]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic recv(input logic [1:0] s, input logic [1:0] ins);
        src_id = s;
        instruction = ins;
        recv_valid = 1'b1;
        tick();
        recv_valid = 1'b0;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        tx_valid = 1'b0;
        send_grant = 1'b0;
        recv_valid = 1'b0;
        rx_ready = 1'b0;
        done_clear = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        tick();
    endtask

    logic [1:0] ins5 [5] = '{2'd3, 2'd2, 2'd3, 2'd2, 2'd3};
    logic [1:0] seq4 [5] = '{2'd0, 2'd2, 2'd1, 2'd0, 2'd2};
    logic [1:0] exp4 [5] = '{2'd1, 2'd0, 2'd2, 2'd2, 2'd0};

    initial begin
        do_reset();
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_send_req", send_req, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_state", core_state, 0);

        // 1: single send, grant two cycles after request
        tx_valid = 1'b1; tx_dst_id = 2'd2; tx_instr = 2'd2;
        tx_broadcast = 1'b0;
        tick();
        tx_valid = 1'b0;
        chk("t1_req_c1", send_req, 1);
        chk("t1_dst", dst_id, 2);
        chk("t1_busy", tx_ready, 0);
        tick();
        chk("t1_req_c2", send_req, 1);
        send_grant = 1'b1;
        #1;
        chk("t1_req_grant", send_req, 0);
        chk("t1_ready_grant", tx_ready, 1);
        tick();
        send_grant = 1'b0;
        #1;
        chk("t1_req_after", send_req, 0);
        chk("t1_ready_after", tx_ready, 1);
        tick();
        chk("t1_one_grant", send_req, 0);

        // 2: back-to-back load on the grant cycle
        tx_valid = 1'b1; tx_dst_id = 2'd1; tx_instr = 2'd1;
        tx_broadcast = 1'b1;
        tick();
        tx_valid = 1'b0;
        chk("t2_req_a", send_req, 1);
        chk("t2_bc_a", broadcast_mode, 1);
        send_grant = 1'b1;
        tx_valid = 1'b1; tx_dst_id = 2'd3; tx_instr = 2'd3;
        tx_broadcast = 1'b0;
        #1;
        chk("t2_ready_grant", tx_ready, 1);
        tick();
        send_grant = 1'b0;
        tx_valid = 1'b0;
        #1;
        chk("t2_req_b", send_req, 1);
        chk("t2_dst_b", dst_id, 3);
        chk("t2_instr_b", instr_out, 3);
        chk("t2_bc_b", broadcast_mode, 0);
        send_grant = 1'b1;
        tick();
        send_grant = 1'b0;
        tick();
        chk("t2_idle", send_req, 0);

        // 3a: five pushes into a 4-deep FIFO without popping
        do_reset();
        for (int i = 0; i < 5; i++) recv(2'(i % 4), ins5[i]);
        chk("t3_overflow", rx_overflow, 1);
        for (int k = 0; k < 4; k++) begin
            chk("t3_src", rx_src_id, k);
            chk("t3_instr", rx_instr, ins5[k]);
            rx_ready = 1'b1;
            tick();
            rx_ready = 1'b0;
        end
        chk("t3_empty", rx_valid, 0);

        // 3b: fifth push coincides with a pop
        do_reset();
        for (int i = 0; i < 4; i++) recv(2'(i % 4), ins5[i]);
        rx_ready = 1'b1;
        recv(2'd0, ins5[4]);
        rx_ready = 1'b0;
        chk("t3b_no_ovf", rx_overflow, 0);
        for (int k = 1; k < 5; k++) begin
            chk("t3b_src", rx_src_id, k % 4);
            chk("t3b_instr", rx_instr, ins5[k]);
            rx_ready = 1'b1;
            tick();
            rx_ready = 1'b0;
        end
        chk("t3b_empty", rx_valid, 0);

        // 4: run-state sequence
        do_reset();
        for (int i = 0; i < 5; i++) begin
            recv(2'd1, seq4[i]);
            chk("t4_state", core_state, exp4[i]);
        end

        // 5: DONE mask with coincident clear
        do_reset();
        recv(2'd3, 2'd3);
        chk("t5_mask_a", done_mask, 4'b1000);
        done_clear = 1'b1;
        recv(2'd1, 2'd3);
        done_clear = 1'b0;
        chk("t5_mask_b", done_mask, 4'b0010);
        done_clear = 1'b1;
        tick();
        done_clear = 1'b0;
        chk("t5_mask_c", done_mask, 4'b0000);

        // 6: asynchronous reset mid-transfer
        do_reset();
        tx_valid = 1'b1; tx_dst_id = 2'd2; tx_instr = 2'd1;
        tx_broadcast = 1'b1;
        tick();
        tx_valid = 1'b0;
        recv(2'd1, 2'd3);
        recv(2'd2, 2'd0);
        chk("t6_pre_rx", rx_valid, 1);
        chk("t6_pre_req", send_req, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_req", send_req, 0);
        chk("t6_ready", tx_ready, 1);
        chk("t6_bc", broadcast_mode, 0);
        chk("t6_dst", dst_id, 0);
        chk("t6_instr_out", instr_out, 0);
        chk("t6_rx_valid", rx_valid, 0);
        chk("t6_rx_src", rx_src_id, 0);
        chk("t6_rx_instr", rx_instr, 0);
        chk("t6_ovf", rx_overflow, 0);
        chk("t6_state", core_state, 0);
        chk("t6_done", done_mask, 0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        tick();
        tick();
        chk("t6_post_req", send_req, 0);
        chk("t6_post_rx", rx_valid, 0);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
